// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: bundle between the game FSM (master) and the display
// scanner (slave).
//   enable      scan advance enable
//   digit_data  nibble i = digit i value
//   blank_mask  1 = digit i dark
//   flash_mask  1 = digit i flashes
//   load        capture digit_data / blank_mask / flash_mask
//   segout      segments gfedcba, active-low
//   anode_out   digit select, active-low one-hot
//   frame_tick  one-cycle pulse at each frame start
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      enable;
   logic [4*NUM_DIGITS-1:0]   digit_data;
   logic [NUM_DIGITS-1:0]     blank_mask;
   logic [NUM_DIGITS-1:0]     flash_mask;
   logic                      load;
   logic [6:0]                segout;
   logic [NUM_DIGITS-1:0]     anode_out;
   logic                      frame_tick;

   modport master (
      output enable, digit_data, blank_mask, flash_mask, load,
      input  segout, anode_out, frame_tick
   );

   modport slave (
      input  enable, digit_data, blank_mask, flash_mask, load,
      output segout, anode_out, frame_tick
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed hex display scanner. One shared decoder
// is walked across NUM_DIGITS digit slots of PRESCALE clocks each. New
// digit data and masks are staged in pending registers and only become
// active at a frame boundary, so a frame is never shown half old/half new.
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   seg_scan_ctrl_if slave modport (inputs from game FSM, pin outputs)
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000,
   parameter int FLASH_DIV  = 8
) (
   input  logic             clk,
   input  logic             rst,
   seg_scan_ctrl_if.slave   bus
);
   localparam int PW = $clog2(PRESCALE);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam int DW = 4 * NUM_DIGITS;

   localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FC_LAST  = FW'(FLASH_DIV - 1);

   function automatic logic [6:0] hex2seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;   4'h1: s = 7'h79;   4'h2: s = 7'h24;   4'h3: s = 7'h30;
         4'h4: s = 7'h19;   4'h5: s = 7'h12;   4'h6: s = 7'h02;   4'h7: s = 7'h78;
         4'h8: s = 7'h00;   4'h9: s = 7'h10;   4'hA: s = 7'h08;   4'hB: s = 7'h03;
         4'hC: s = 7'h46;   4'hD: s = 7'h21;   4'hE: s = 7'h06;   default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [PW-1:0]         prescale_q, prescale_d;
   logic [IW-1:0]         index_q, index_d;
   logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
   logic                  phase_q, phase_d;
   logic [DW-1:0]         pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
   logic [NUM_DIGITS-1:0] pend_flash_q, pend_flash_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [DW-1:0]         act_data_q, act_data_d;
   logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
   logic [NUM_DIGITS-1:0] act_flash_q, act_flash_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  tick_q, tick_d;

   logic       slot_end, boundary, cur_blank, cur_flash, dark;
   logic [3:0] cur_nib;

   always_comb begin
      prescale_d   = prescale_q;
      index_d      = index_q;
      frame_cnt_d  = frame_cnt_q;
      phase_d      = phase_q;
      pend_data_d  = pend_data_q;
      pend_blank_d = pend_blank_q;
      pend_flash_d = pend_flash_q;
      pend_valid_d = pend_valid_q;
      act_data_d   = act_data_q;
      act_blank_d  = act_blank_q;
      act_flash_d  = act_flash_q;

      slot_end = bus.enable && (prescale_q == PS_LAST);
      boundary = slot_end && (index_q == IDX_LAST);

      if (slot_end) begin
         prescale_d = '0;
         index_d    = (index_q == IDX_LAST) ? '0 : index_q + IW'(1);
      end else if (bus.enable) begin
         prescale_d = prescale_q + PW'(1);
      end

      if (boundary) begin
         frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FW'(1);
         if (frame_cnt_q == FC_LAST) phase_d = ~phase_q;
         // A load landing on the boundary itself goes straight to the
         // active set; any older staged data is dropped with it.
         if (bus.load) begin
            act_data_d  = bus.digit_data;
            act_blank_d = bus.blank_mask;
            act_flash_d = bus.flash_mask;
         end else if (pend_valid_q) begin
            act_data_d  = pend_data_q;
            act_blank_d = pend_blank_q;
            act_flash_d = pend_flash_q;
         end
         pend_valid_d = 1'b0;
      end else if (bus.load) begin
         pend_data_d  = bus.digit_data;
         pend_blank_d = bus.blank_mask;
         pend_flash_d = bus.flash_mask;
         pend_valid_d = 1'b1;
      end

      tick_d = boundary;

      // Output stage looks at the current (pre-advance) slot, hence the
      // one-cycle lag between an index change and the pins.
      cur_nib   = '0;
      cur_blank = 1'b0;
      cur_flash = 1'b0;
      anode_d   = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (index_q == IW'(i)) begin
            cur_nib    = act_data_q[4*i +: 4];
            cur_blank  = act_blank_q[i];
            cur_flash  = act_flash_q[i];
            anode_d[i] = 1'b0;
         end
      end
      dark  = cur_blank | (cur_flash & phase_q);
      seg_d = hex2seg(cur_nib);
      if (dark) begin
         seg_d   = 7'h7F;
         anode_d = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale_q   <= '0;
         index_q      <= '0;
         frame_cnt_q  <= '0;
         phase_q      <= 1'b0;
         pend_data_q  <= '0;
         pend_blank_q <= '0;
         pend_flash_q <= '0;
         pend_valid_q <= 1'b0;
         act_data_q   <= '0;
         act_blank_q  <= '1;
         act_flash_q  <= '0;
         seg_q        <= 7'h7F;
         anode_q      <= '1;
         tick_q       <= 1'b0;
      end else begin
         prescale_q   <= prescale_d;
         index_q      <= index_d;
         frame_cnt_q  <= frame_cnt_d;
         phase_q      <= phase_d;
         pend_data_q  <= pend_data_d;
         pend_blank_q <= pend_blank_d;
         pend_flash_q <= pend_flash_d;
         pend_valid_q <= pend_valid_d;
         act_data_q   <= act_data_d;
         act_blank_q  <= act_blank_d;
         act_flash_q  <= act_flash_d;
         seg_q        <= seg_d;
         anode_q      <= anode_d;
         tick_q       <= tick_d;
      end
   end

   assign bus.segout     = seg_q;
   assign bus.anode_out  = anode_q;
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4, FLASH_DIV=2).
// Stimulus pushes the expected pin state for each clock into a queue; a
// negedge monitor pops and compares.
module tb_seg_scan_ctrl;
   logic clk = 1'b0;
   logic rst;

   seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

   seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .FLASH_DIV(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
      logic       tick;
      string      tag;
   } exp_t;

   typedef struct {
      int          at;
      logic [15:0] d;
      logic [3:0]  b;
      logic [3:0]  f;
   } ld_t;

   localparam ld_t NO_LD = ld_t'{at: -1, d: 16'h0, b: 4'h0, f: 4'h0};

   // Active-low gfedcba patterns for 0..F.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   nbound = 0;
   int   frame_no = 0;

   task automatic step(input logic [6:0] s, input logic [3:0] a, input logic t, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      e.seg = s; e.an = a; e.tick = t; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive_ld(input ld_t l);
      bus.load       = 1'b1;
      bus.digit_data = l.d;
      bus.blank_mask = l.b;
      bus.flash_mask = l.f;
   endtask

   // One 16-clock output frame showing `data` with the given masks.
   // Entry o shows digit o/4; the boundary tick lands on entry 15.
   task automatic frame(input logic [15:0] data, input logic [3:0] blank, input logic [3:0] flash,
                        input ld_t l1, input ld_t l2, input int hold_at, input int rst_at);
      bit         phase;
      int         d;
      logic       dark;
      logic [3:0] nib;
      logic [6:0] es;
      logic [3:0] ea;
      string      tag;
      phase = ((nbound / 2) % 2) == 1;
      for (int o = 0; o < 16; o++) begin
         d    = o / 4;
         nib  = data[4*d +: 4];
         dark = blank[d] | (flash[d] & phase);
         es   = dark ? 7'h7F : seg_tab[nib];
         ea   = dark ? 4'hF : (4'hF ^ (4'b0001 << d));
         tag  = $sformatf("frame%0d.%0d", frame_no, o);
         if (o == hold_at) begin
            bus.load   = 1'b0;
            bus.enable = 1'b0;
            repeat (10) step(es, ea, 1'b0, {tag, ".hold"});
            bus.enable = 1'b1;
         end
         if (o == rst_at) begin
            rst            = 1'b1;
            bus.load       = 1'b1;
            bus.digit_data = 16'h7777;
            bus.blank_mask = 4'h0;
            bus.flash_mask = 4'h0;
            step(7'h7F, 4'hF, 1'b0, "reset_mid");
            rst      = 1'b0;
            bus.load = 1'b0;
            nbound   = 0;
            frame_no++;
            return;
         end
         bus.load = 1'b0;
         if (o == l1.at) drive_ld(l1);
         if (o == l2.at) drive_ld(l2);
         step(es, ea, (o == 15), tag);
      end
      bus.load = 1'b0;
      nbound++;
      frame_no++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.segout !== e.seg || bus.anode_out !== e.an || bus.frame_tick !== e.tick) begin
            errors++;
            $display("FAIL %s: got seg=%h an=%h tick=%b, want seg=%h an=%h tick=%b",
                     e.tag, bus.segout, bus.anode_out, bus.frame_tick, e.seg, e.an, e.tick);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.enable     = 1'b0;
      bus.load       = 1'b0;
      bus.digit_data = 16'h0;
      bus.blank_mask = 4'h0;
      bus.flash_mask = 4'h0;
      repeat (3) step(7'h7F, 4'hF, 1'b0, "reset");
      rst        = 1'b0;
      bus.enable = 1'b1;

      // Dark until the first boundary; 3A70 staged on the first clock.
      frame(16'h0000, 4'hF, 4'h0, ld_t'{0, 16'h3A70, 4'h0, 4'h0}, NO_LD, -1, -1);
      // Two loads mid-frame: last one (FFFF, at digit 1 prescaler 1) wins.
      frame(16'h3A70, 4'h0, 4'h0, ld_t'{2, 16'h9999, 4'h0, 4'h0},
            ld_t'{5, 16'hFFFF, 4'h0, 4'h0}, -1, -1);
      // 5555 staged, then 1234 bypasses at the boundary and drops 5555.
      frame(16'hFFFF, 4'h0, 4'h0, ld_t'{3, 16'h5555, 4'h0, 4'h0},
            ld_t'{15, 16'h1234, 4'h0, 4'h0}, -1, -1);
      frame(16'h1234, 4'h0, 4'h0, NO_LD, NO_LD, -1, -1);
      frame(16'h1234, 4'h0, 4'h0, ld_t'{8, 16'h1234, 4'h8, 4'h2}, NO_LD, -1, -1);
      // Flashing digit 1: lit, dark, dark, lit; digit 3 always blank.
      frame(16'h1234, 4'h8, 4'h2, NO_LD, NO_LD, 6, -1);
      frame(16'h1234, 4'h8, 4'h2, NO_LD, NO_LD, -1, -1);
      frame(16'h1234, 4'h8, 4'h2, NO_LD, NO_LD, -1, -1);
      frame(16'h1234, 4'h8, 4'h2, NO_LD, NO_LD, -1, -1);
      // Reset mid-frame with load high; load must be ignored.
      frame(16'h1234, 4'h8, 4'h2, NO_LD, NO_LD, -1, 9);
      frame(16'h0000, 4'hF, 4'h0, NO_LD, NO_LD, -1, -1);
      frame(16'h0000, 4'hF, 4'h0, ld_t'{4, 16'hC0DE, 4'h0, 4'h0}, NO_LD, -1, -1);
      frame(16'hC0DE, 4'h0, 4'h0, NO_LD, NO_LD, -1, -1);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
